// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access: data priority with an
// instruction starvation guard. Define MEM_ARBITER_LLSC_EN to add LL/SC link tracking.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    input  logic              datomic,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;
    logic             i_done;
    logic             d_done;
    logic             sc_op;
    logic             sc_fail;

    assign d_req = dREN | dWEN;

`ifdef MEM_ARBITER_LLSC_EN
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;
    logic              link_hit;
    logic              ll_op;

    assign link_hit = link_valid && (link_addr == daddr);
    assign ll_op    = dREN & datomic;
    assign sc_op    = dWEN & datomic;
    assign sc_fail  = sc_op & ~link_hit;

    // Link register: set by LL, consumed by a successful SC, broken by a plain store to it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (d_done) begin
            if (ll_op) begin
                link_valid <= 1'b1;
                link_addr  <= daddr;
            end else if (sc_op) begin
                if (link_hit) begin
                    link_valid <= 1'b0;
                end
            end else if (dWEN && (link_addr == daddr)) begin
                link_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_datomic;

    assign unused_datomic = datomic;
    assign sc_op          = 1'b0;
    assign sc_fail        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data grants made while fetch waits; saturates so fetch wins the next arbitration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || i_done) begin
            starve_cnt <= '0;
        end else if (d_done && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Grant sequencing, RAM drive and same-cycle completion signalling.
    always_comb begin
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && (starve_cnt < LIMIT)) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end else if (d_req) begin
                    state_next = DGRANT;
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        i_done     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else if (sc_fail) begin
                    // Failed SC never touches the RAM.
                    dwait      = 1'b0;
                    d_done     = 1'b1;
                    state_next = IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        dload      = sc_op ? ADDR_W'(1) : ramload;
                        d_done     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch path and the data-memory path of the pipelined datapath.
- Sits between the instruction and data cache-side request ports and the RAM model.
- Arbitrates with data priority plus a starvation guard for instruction fetch.
- Sequences each transfer through a grant FSM that runs to completion on the RAM handshake.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while an instruction request is pending; after this many, instruction wins the next arbitration. Range 1–15.
- ADDR_W, 32: address and data width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  1 = instruction request not yet complete.
- iload  out  ADDR_W  instruction read data; valid when iREN=1 and iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both 1.
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  data write value.
- datomic  in  1  current data access is LL (read) or SC (write).
- dwait  out  1  1 = data request not yet complete.
- dload  out  ADDR_W  data read value, or SC result.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (async, nRST=0): state=IDLE, starve count=0, link invalid.
  - Outputs during reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
- FSM states: IDLE, IGRANT, DGRANT. The grant state is registered.
- RAM drive:
  - In IGRANT: ramREN=1, ramaddr=iaddr.
  - In DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - In IDLE all RAM strobes are 0.
- IDLE transitions:
  - Next state is DGRANT if a data request (dREN|dWEN) is present and the starve count < STARVE_LIMIT.
  - Otherwise IGRANT if iREN=1.
  - Otherwise DGRANT if a data request is present.
  - Otherwise stay IDLE.
- Minimum latency: request seen in cycle 0, strobes asserted in cycle 1, completion in the first cycle with ramstate=ACCESS.
- Completion:
  - The completion cycle is combinational: the owning wait output goes 0 and iload/dload = ramload in that same cycle.
  - Next state is IDLE. No back-to-back grant without an IDLE cycle.
- BUSY, FREE or ERROR while granted: hold the grant, keep the wait output at 1, keep the strobes asserted.
- Starve count:
  - Increments on each DGRANT completion while iREN=1, saturating at STARVE_LIMIT.
  - Clears on IGRANT completion or whenever iREN=0.
- Requester drops mid-grant (the owning REN/WEN falls to 0 before ACCESS): abort. Strobes go 0 in that cycle, next state is IDLE, no completion is signalled.
- The non-granted wait output is always 1.
- The wait output for an idle requester (no request) is 1.

Optional Feature:
- Macro: MEM_ARBITER_LLSC_EN
- Enabled, single link register (valid + address):
  - LL (dREN & datomic) completion sets valid=1 and link address=daddr.
  - SC (dWEN & datomic) when link valid and address equal: performs the RAM write; on completion dload=1 and the link is cleared.
  - SC that fails: no RAM strobe. Completes in the first DGRANT cycle with dwait=0 and dload=0, then IDLE.
  - Any non-atomic write completion to the linked address clears the link.
  - Reset clears the link.
- Disabled: datomic is ignored; SC behaves as a plain write and dload=ramload.

Test Plan:
1. Reset with no requests -> all strobes 0, iwait=dwait=1.
   - iREN=1, iaddr=0x40, ramstate=ACCESS at cycle 2 -> ramREN=1 in cycles 1–2, iwait=0 and iload=ramload in cycle 2, IDLE in cycle 3.
2. iREN and dREN simultaneous from IDLE, daddr=0x100 -> DGRANT first.
   - After data completes, IGRANT follows.
   - dwait stays 1 while IGRANT is active.
3. iREN held, dREN re-asserted continuously, STARVE_LIMIT=4 -> exactly 4 data completions, then one IGRANT, then the count resets.
4. DGRANT write with ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 through all cycles, dwait=0 only on the ACCESS cycle.
   - Deasserting dWEN mid-BUSY instead -> ramWEN=0 that cycle, IDLE next, dwait never 0.
5. nRST pulsed low during DGRANT -> strobes drop immediately and asynchronously, state is IDLE after release.
6. (LLSC_EN) LL 0x200, then SC 0x200 -> write performed, dload=1.
   - Second SC to 0x200 -> no ramWEN, dload=0.
   - LL 0x200, then plain SW 0x200, then SC 0x200 -> SC fails.
